// File: rtl/fir_coeff_loader.sv
// Streams NUM_REGS coefficients into the FIR accelerator register file, one word
// per cycle from address 0, holding the accelerator enable low for the whole load.
module fir_coeff_loader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         coeffValid,
  input  logic signed [DATA_WIDTH-1:0] coeffData,
  output logic                         coeffReady,
  output logic                         coeffWriteEn,
  output logic        [ADDR_WIDTH-1:0] coeffAddress,
  output logic signed [DATA_WIDTH-1:0] coeffsOut,
  input  logic                         accelerateReq,
  output logic                         accelerateEn,
  output logic                         busy,
  output logic                         done,
  output logic          [ADDR_WIDTH:0] writeCount
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH:0]   MAX_COUNT = (ADDR_WIDTH + 1)'(NUM_REGS);

  state_t                         state_q,  state_d;
  logic        [ADDR_WIDTH-1:0]   index_q,  index_d;
  logic                           ready_q,  ready_d;
  logic                           we_q,     we_d;
  logic        [ADDR_WIDTH-1:0]   addr_q,   addr_d;
  logic signed [DATA_WIDTH-1:0]   data_q,   data_d;
  logic                           done_q,   done_d;
  logic                           busy_q,   busy_d;
  logic        [ADDR_WIDTH:0]     count_q,  count_d;
  logic                           handshake;

  assign handshake = coeffValid & ready_q;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    ready_d = ready_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    count_d = count_q;

    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        if (start && !abort) begin
          state_d = ST_LOAD;
          ready_d = 1'b1;
          busy_d  = 1'b1;
          index_d = '0;
          count_d = '0;
        end
      end

      ST_LOAD: begin
        if (abort) begin
          // A beat accepted alongside abort is dropped; no strobe follows.
          state_d = ST_IDLE;
          ready_d = 1'b0;
          busy_d  = 1'b0;
        end else if (handshake) begin
          we_d    = 1'b1;
          addr_d  = index_q;
          data_d  = coeffData;
          count_d = (count_q < MAX_COUNT) ? count_q + 1'b1 : count_q;
          if (index_q == LAST_IDX) begin
            state_d = ST_DRAIN;
            ready_d = 1'b0;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        ready_d = 1'b0;
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign coeffReady   = ready_q;
  assign coeffWriteEn = we_q;
  assign coeffAddress = addr_q;
  assign coeffsOut    = data_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign writeCount   = count_q;

  // Gated by rst so the enable reads 0 while reset is held, like every other output.
  assign accelerateEn = accelerateReq & ~rst & (state_q == ST_IDLE);

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader: transaction-level model predicts writes and
// done pulses; a negedge monitor pops and compares them against the DUT.
module tb_fir_coeff_loader;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int AW = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic                 coeffValid = 1'b0;
  logic signed [DW-1:0] coeffData = '0;
  logic                 accelerateReq = 1'b0;
  logic                 coeffReady;
  logic                 coeffWriteEn;
  logic        [AW-1:0] coeffAddress;
  logic signed [DW-1:0] coeffsOut;
  logic                 accelerateEn;
  logic                 busy;
  logic                 done;
  logic          [AW:0] writeCount;

  fir_coeff_loader #(
    .DATA_WIDTH(DW),
    .NUM_REGS  (NR),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .coeffValid   (coeffValid),
    .coeffData    (coeffData),
    .coeffReady   (coeffReady),
    .coeffWriteEn (coeffWriteEn),
    .coeffAddress (coeffAddress),
    .coeffsOut    (coeffsOut),
    .accelerateReq(accelerateReq),
    .accelerateEn (accelerateEn),
    .busy         (busy),
    .done         (done),
    .writeCount   (writeCount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];

  typedef enum {M_IDLE, M_LOAD, M_FIN} mst_t;
  mst_t m_state = M_IDLE;
  bit   m_ready = 1'b0;
  int   m_idx   = 0;
  int   m_count = 0;
  int   m_fin   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares every write strobe and done pulse against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (coeffWriteEn) begin
        if (exp_wr.size() == 0) begin
          chk("write_unexpected", 32'(coeffWriteEn), 32'd0);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("write_addr", 32'(coeffAddress), 32'(e.addr));
          chk("write_data", {16'd0, coeffsOut}, {16'd0, e.data});
          chk("write_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else if (exp_wr.size() != 0 && exp_wr[0].cyc <= cyc) begin
        chk("write_missing", 32'(coeffWriteEn), 32'd1);
        void'(exp_wr.pop_front());
      end

      if (done) begin
        if (exp_done.size() == 0) begin
          chk("done_unexpected", 32'(done), 32'd0);
        end else begin
          chk("done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
        end
      end else if (exp_done.size() != 0 && exp_done[0] <= cyc) begin
        chk("done_missing", 32'(done), 32'd1);
        void'(exp_done.pop_front());
      end
    end
  end

  // One clock cycle of stimulus; entered and left 1 time unit after a rising edge.
  task automatic beat(input bit v, input logic [15:0] d, input bit st, input bit ab,
                      input bit areq);
    coeffValid    = v;
    coeffData     = d;
    start         = st;
    abort         = ab;
    accelerateReq = areq;
    #1;
    chk("coeffReady", 32'(coeffReady), 32'(m_ready));
    chk("busy", 32'(busy), 32'(m_state != M_IDLE));
    chk("writeCount", 32'(writeCount), 32'(m_count));
    chk("accelerateEn", 32'(accelerateEn), 32'(areq && m_state == M_IDLE));

    case (m_state)
      M_IDLE: begin
        if (st && !ab) begin
          m_state = M_LOAD;
          m_ready = 1'b1;
          m_idx   = 0;
          m_count = 0;
        end
      end
      M_LOAD: begin
        if (ab) begin
          m_state = M_IDLE;
          m_ready = 1'b0;
        end else if (v) begin
          exp_wr.push_back('{m_idx, d, cyc + 1});
          m_idx++;
          m_count++;
          if (m_idx == NR) begin
            exp_done.push_back(cyc + 2);
            m_state = M_FIN;
            m_fin   = 2;
            m_ready = 1'b0;
          end
        end
      end
      M_FIN: begin
        if (m_fin == 2) begin
          if (ab) begin
            void'(exp_done.pop_back());
            m_state = M_IDLE;
          end else begin
            m_fin = 1;
          end
        end else begin
          m_state = M_IDLE;
        end
      end
      default: m_state = M_IDLE;
    endcase

    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_coeffReady"},   32'(coeffReady),   32'd0);
    chk({tag, "_coeffWriteEn"}, 32'(coeffWriteEn), 32'd0);
    chk({tag, "_coeffAddress"}, 32'(coeffAddress), 32'd0);
    chk({tag, "_coeffsOut"},    {16'd0, coeffsOut}, 32'd0);
    chk({tag, "_done"},         32'(done),         32'd0);
    chk({tag, "_busy"},         32'(busy),         32'd0);
    chk({tag, "_writeCount"},   32'(writeCount),   32'd0);
    chk({tag, "_accelerateEn"}, 32'(accelerateEn), 32'd0);
  endtask

  task automatic async_reset();
    accelerateReq = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midload_rst");
    exp_wr.delete();
    exp_done.delete();
    m_state = M_IDLE;
    m_ready = 1'b0;
    m_count = 0;
    m_idx   = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst = 1'b1;
    accelerateReq = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Back-to-back 0x0033 load.
    beat(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < NR; i++) beat(1'b1, 16'h0033, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Gapped stream with data 1..8.
    beat(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= NR; i++) begin
      beat(1'b1, 16'(i), 1'b0, 1'b0, 1'b1);
      beat(1'b0, 16'hdead, 1'b0, 1'b0, 1'b1);
    end
    idle(3);

    // Abort after three handshakes; the beat offered with abort is dropped.
    beat(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) beat(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b1);
    beat(1'b1, 16'h0bad, 1'b0, 1'b1, 1'b1);
    idle(3);

    // Restart request during a load is ignored.
    beat(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) beat(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0, 1'b1);
    beat(1'b1, 16'h0204, 1'b1, 1'b0, 1'b1);
    for (int i = 5; i < NR; i++) beat(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0, 1'b1);
    idle(3);

    // Asynchronous reset with index at 5, then a clean restart from address 0.
    beat(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) beat(1'b1, 16'(16'h0300 + i), 1'b0, 1'b0, 1'b1);
    async_reset();
    beat(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < NR; i++) beat(1'b1, 16'(16'hff00 + i), 1'b0, 1'b0, 1'b1);
    idle(3);

    // start together with abort in IDLE.
    beat(1'b1, 16'h1234, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) beat(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      beat(($urandom % 3) != 0, 16'($urandom), ($urandom % 6) == 0,
           ($urandom % 40) == 0, ($urandom % 2) == 0);
    end
    idle(5);

    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    chk("done_queue_empty", 32'(exp_done.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
- Hardware initiator for the FIR accelerator's coefficient-write interface. It replaces testbench-driven coefficient loading.
- Accepts NUM_REGS fixed-point coefficients over a valid/ready stream and drives coeffWriteEn/coeffAddress/coeffsOut into the accelerator register file, one word per cycle, starting at address 0.
- Holds the accelerator's enable low for the whole load, then signals completion.

Parameters:
- DATA_WIDTH, 16, coefficient word width (same fixed-point format as the accelerator).
- NUM_REGS, 8, number of coefficient registers to write per load.
- ADDR_WIDTH, 3, coefficient address width; must satisfy 2**ADDR_WIDTH >= NUM_REGS.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to begin a load; honoured only in IDLE
- abort  input  1  cancels a load in progress
- coeffValid  input  1  upstream coefficient word valid
- coeffData  input  DATA_WIDTH  signed upstream coefficient word
- coeffReady  output  1  loader can accept coeffData this cycle
- coeffWriteEn  output  1  write strobe to accelerator register file
- coeffAddress  output  ADDR_WIDTH  register-file write address
- coeffsOut  output  DATA_WIDTH  signed write data to register file
- accelerateReq  input  1  system request to run the accelerator
- accelerateEn  output  1  gated accelerator enable
- busy  output  1  load in progress (LOAD, DRAIN or DONE)
- done  output  1  one-cycle pulse on successful completion
- writeCount  output  ADDR_WIDTH+1  words written in current/last load

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state IDLE, coeffReady=0, coeffWriteEn=0, coeffAddress=0, coeffsOut=0, done=0, busy=0, writeCount=0, accelerateEn=0.
- States:
  - IDLE: coeffReady=0, busy=0. start=1 -> LOAD, clear index and writeCount.
  - LOAD: coeffReady=1. On a handshake (coeffValid&coeffReady) in cycle N:
    - cycle N+1: coeffWriteEn=1, coeffAddress=index, coeffsOut=coeffData captured at N.
    - index increments.
    - writeCount increments in cycle N+1.
    - When the handshake is for index NUM_REGS-1 -> DRAIN.
    - coeffValid=0: coeffWriteEn=0 next cycle; stays in LOAD, no timeout.
  - DRAIN: coeffReady=0; last write strobe visible this cycle; -> DONE.
  - DONE: done=1 for exactly one cycle, coeffWriteEn=0; -> IDLE.
- Write strobe rules:
  - Back-to-back valid beats give consecutive write strobes, addresses 0,1,…,NUM_REGS-1, no gaps.
  - Addresses never wrap within a load.
  - No write strobe is ever issued outside LOAD/DRAIN.
- accelerateEn = accelerateReq & (state==IDLE), combinational from the registered state; forced 0 during any load.
- Simultaneous events and aborts:
  - start while busy: ignored.
  - start and abort together in IDLE: abort wins, stay IDLE.
  - abort in LOAD/DRAIN: -> IDLE next cycle, coeffReady=0 and coeffWriteEn=0 from that cycle. A beat accepted in the abort cycle is discarded (no write).
  - After abort: done never pulses; writeCount holds the partial count; already-written registers are not restored.
  - abort in DONE: done still pulses; return to IDLE.
- Reset mid-load: immediate return to reset values. The register file keeps whatever was written.
- Data rules: coeffsOut is a bit-exact copy of coeffData; no scaling or rounding.
- writeCount saturates at NUM_REGS and holds until the next start.

Test Plan:
- Reset then start, then 8 back-to-back beats 0x0033 (0.2 in Q8): write strobes on 8 consecutive cycles with addresses 0..7 and data 0x0033; done pulses 2 cycles after the last handshake; writeCount=8; accelerateEn=0 throughout with accelerateReq=1, then 1 once IDLE.
- Gapped stream: coeffValid low on alternate cycles with data 1..8: writes occur only after valid cycles; addresses stay 0..7 mapping to data 1..8; no duplicate addresses.
- abort after 3 handshakes: exactly 3 writes (addr 0..2); no done; writeCount=3; coeffReady=0 the cycle after abort.
- start pulsed again mid-load (after 4 beats): ignored; addresses continue 4..7; exactly one done.
- rst asserted asynchronously mid-cycle during LOAD at index 5: all outputs go to 0 before the next clock edge; a following start restarts at address 0.
- start and abort in the same IDLE cycle: stays IDLE; coeffReady stays 0; no writes.
